// File: rtl/slave_tag_allocator.sv
// slave_tag_allocator
//   Hands out transaction tags for non-posted requests and takes them back
//   when the matching completion has finished. Free tags live in a circular
//   free list; a per-tag bitmap marks which tags are currently in flight so
//   that bogus or duplicate releases can be detected and rejected.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   alloc_valid / alloc_info  request needing a tag, plus the info to record
//   alloc_ready / alloc_tag   a tag is available / the tag granted this cycle
//   rel_valid / rel_tag       return a tag to the free list
//   req_wr_en/addr/data       recorder write, one cycle after each grant
//   outstanding               number of tags currently in flight
//   err_bad_release           sticky flag: a non-allocated tag was released
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | seeding free list with tags 0..NUM_TAGS-1, one per cycle
// ST_RUN  | normal allocate / release operation
module slave_tag_allocator #(
  parameter int TAG_W      = 8,
  parameter int REC_DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  alloc_valid,
  input  logic [REC_DATA_W-1:0] alloc_info,
  output logic                  alloc_ready,
  output logic [TAG_W-1:0]      alloc_tag,
  input  logic                  rel_valid,
  input  logic [TAG_W-1:0]      rel_tag,
  output logic                  req_wr_en,
  output logic [TAG_W-1:0]      req_wr_addr,
  output logic [REC_DATA_W-1:0] req_wr_data,
  output logic [TAG_W:0]        outstanding,
  output logic                  err_bad_release
);

  localparam int NUM_TAGS = 1 << TAG_W;
  localparam logic [TAG_W:0] PTR_ONE = {{TAG_W{1'b0}}, 1'b1};

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [TAG_W:0]          r_rd_ptr;
  logic [TAG_W:0]          r_wr_ptr;
  logic [NUM_TAGS-1:0]     r_bitmap;
  logic [TAG_W-1:0]        r_fifo [NUM_TAGS];
  logic [TAG_W:0]          r_outstanding;
  logic                    r_req_wr_en;
  logic [TAG_W-1:0]        r_req_wr_addr;
  logic [REC_DATA_W-1:0]   r_req_wr_data;
  logic                    r_err;

  logic                    w_run;
  logic                    w_fl_empty;
  logic                    w_fl_full;
  logic                    w_init_last;
  logic                    w_alloc_ready;
  logic                    w_alloc_fire;
  logic                    w_rel_hit;
  logic                    w_rel_ok;
  logic                    w_rel_bad;
  logic                    w_fifo_we;
  logic [TAG_W-1:0]        w_fifo_wdata;
  logic [TAG_W-1:0]        w_alloc_tag;

  assign w_run       = (r_state == ST_RUN);
  assign w_fl_empty  = (r_wr_ptr == r_rd_ptr);
  // Pointers carry one extra wrap bit: equal low bits with differing MSBs means full.
  assign w_fl_full   = (r_wr_ptr[TAG_W] != r_rd_ptr[TAG_W]) &&
                       (r_wr_ptr[TAG_W-1:0] == r_rd_ptr[TAG_W-1:0]);
  assign w_init_last = (r_state == ST_INIT) && (&r_wr_ptr[TAG_W-1:0]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_INIT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_alloc_ready = 1'b0;
    case (r_state)
      ST_INIT: if (w_init_last) w_state_nxt = ST_RUN;
      ST_RUN:  w_alloc_ready = !w_fl_empty;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  assign w_alloc_tag  = r_fifo[r_rd_ptr[TAG_W-1:0]];
  assign w_alloc_fire = alloc_valid & w_alloc_ready;

  // Release legality is judged on the bitmap as it stood before this cycle,
  // so releasing the tag being granted in the same cycle counts as bad.
  assign w_rel_hit = r_bitmap[rel_tag];
  assign w_rel_ok  = rel_valid & w_run & w_rel_hit & ~w_fl_full;
  assign w_rel_bad = rel_valid & w_run & ~w_rel_hit;

  assign w_fifo_we    = (r_state == ST_INIT) | w_rel_ok;
  assign w_fifo_wdata = w_run ? rel_tag : r_wr_ptr[TAG_W-1:0];

  // Free-list storage is overwritten by INIT after every reset, so it needs none.
  always_ff @(posedge clk) begin
    if (w_fifo_we) r_fifo[r_wr_ptr[TAG_W-1:0]] <= w_fifo_wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_alloc_fire)                   r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if ((r_state == ST_INIT) || w_rel_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
    end
  end

  // A granted tag always has a clear bit and a good release a set bit,
  // so the two updates below never touch the same bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bitmap <= '0;
    end else begin
      if (w_alloc_fire) r_bitmap[w_alloc_tag] <= 1'b1;
      if (w_rel_ok)     r_bitmap[rel_tag]     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_outstanding <= '0;
    end else begin
      case ({w_alloc_fire, w_rel_ok})
        2'b10:   r_outstanding <= r_outstanding + PTR_ONE;
        2'b01:   r_outstanding <= r_outstanding - PTR_ONE;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_req_wr_en   <= 1'b0;
      r_req_wr_addr <= '0;
      r_req_wr_data <= '0;
      r_err         <= 1'b0;
    end else begin
      r_req_wr_en <= w_alloc_fire;
      if (w_alloc_fire) begin
        r_req_wr_addr <= w_alloc_tag;
        r_req_wr_data <= alloc_info;
      end
      if (w_rel_bad) r_err <= 1'b1;
    end
  end

  assign alloc_ready     = w_alloc_ready;
  assign alloc_tag       = w_alloc_tag;
  assign req_wr_en       = r_req_wr_en;
  assign req_wr_addr     = r_req_wr_addr;
  assign req_wr_data     = r_req_wr_data;
  assign outstanding     = r_outstanding;
  assign err_bad_release = r_err;

endmodule

// File: doc/slave_tag_allocator.md
SLAVE_TAG_ALLOCATOR -- requirements
Module: slave_tag_allocator

Interface
REQ-001 SHALL have parameter TAG_W, default 8, tag width; NUM_TAGS = 2**TAG_W (256).
REQ-002 SHALL have parameter REC_DATA_W, default 16, width of request info written to the request recorder.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port alloc_valid  input  1  non-posted request needs a tag.
REQ-006 SHALL have port alloc_info  input  REC_DATA_W  request info (AXI ID, length) to record.
REQ-007 SHALL have port alloc_ready  output  1  tag available this cycle.
REQ-008 SHALL have port alloc_tag  output  TAG_W  tag granted on handshake.
REQ-009 SHALL have port rel_valid  input  1  completion finished; free a tag.
REQ-010 SHALL have port rel_tag  input  TAG_W  tag to free.
REQ-011 SHALL have port req_wr_en  output  1  recorder write strobe.
REQ-012 SHALL have port req_wr_addr  output  TAG_W  recorder write address (the tag).
REQ-013 SHALL have port req_wr_data  output  REC_DATA_W  recorder write data.
REQ-014 SHALL have port outstanding  output  TAG_W+1  count of allocated tags.
REQ-015 SHALL have port err_bad_release  output  1  sticky; release of a non-allocated tag.

Function
REQ-016 SHALL keep a free-list FIFO of NUM_TAGS entries (rd_ptr, wr_ptr, TAG_W+1 bits each) and a NUM_TAGS-bit allocated bitmap.
REQ-017 SHALL run FSM INIT -> RUN; INIT writes tag k into free-list entry k for k = 0..NUM_TAGS-1, one per cycle; after entry NUM_TAGS-1 is written, wr_ptr = NUM_TAGS and state -> RUN.
REQ-018 SHALL drive alloc_ready = 1 only in RUN with free-list non-empty (wr_ptr != rd_ptr).
REQ-019 SHALL drive alloc_tag = free-list entry at rd_ptr, combinationally, valid whenever alloc_ready = 1.
REQ-020 SHALL, on alloc_valid & alloc_ready, increment rd_ptr, set bitmap[alloc_tag], increment outstanding.
REQ-021 SHALL, one cycle after the handshake, pulse req_wr_en = 1 for one cycle with req_wr_addr = granted tag and req_wr_data = alloc_info captured at the handshake.
REQ-022 SHALL, on rel_valid in RUN with bitmap[rel_tag] = 1, write rel_tag at wr_ptr, increment wr_ptr, clear bitmap[rel_tag], decrement outstanding.
REQ-023 SHALL, on rel_valid in RUN with bitmap[rel_tag] = 0, leave FIFO, bitmap and count unchanged and set err_bad_release = 1 until reset.
REQ-024 SHALL ignore rel_valid in INIT with no error flagged.
REQ-025 SHALL handle simultaneous allocation and valid release in one cycle: both pointers advance, outstanding unchanged.
REQ-026 SHALL, when the free list is empty (outstanding = NUM_TAGS), hold alloc_ready = 0; a release that cycle re-asserts alloc_ready the next cycle with alloc_tag = released tag.
REQ-027 SHALL, on simultaneous allocation and release of the same tag value, treat allocation as granted from the pre-cycle bitmap and release as a bad release if the bit was 0 before the cycle.
REQ-028 SHALL wrap pointers modulo 2*NUM_TAGS; full/empty derived from MSB compare.
REQ-029 SHALL never grant a tag whose bitmap bit is set; no tag appears twice in flight.

Reset
REQ-030 SHALL, on rstn = 0 at any time, asynchronously force state = INIT, rd_ptr = wr_ptr = 0, bitmap = 0, outstanding = 0, alloc_ready = 0, req_wr_en = 0, req_wr_addr = 0, req_wr_data = 0, err_bad_release = 0.
REQ-031 SHALL, on reset mid-operation, discard all outstanding tags and restart INIT; free-list storage itself needs no reset.

Verification
REQ-032 Reset release, idle -> alloc_ready = 0 for 256 cycles, then 1 with alloc_tag = 0, outstanding = 0.
REQ-033 Three back-to-back allocations with alloc_info = 'h0011, 'h0022, 'h0033 -> tags 0, 1, 2; req_wr_en pulses on the following cycles with addr/data 0/'h0011, 1/'h0022, 2/'h0033; outstanding = 3.
REQ-034 Allocate all 256 tags -> alloc_ready = 0, outstanding = 256; release tag 'h5A -> next cycle alloc_ready = 1, alloc_tag = 'h5A.
REQ-035 With tags 0..3 allocated, same-cycle allocate and release tag 1 -> allocation granted tag 4, outstanding stays 4, tag 1 queued at tail.
REQ-036 Release tag 'h80 never allocated -> err_bad_release = 1 and stays 1, outstanding unchanged; double release of tag 0 -> same.
REQ-037 Assert rstn = 0 with 10 tags outstanding -> all outputs at reset values immediately; after release, INIT repeats and tag 0 is granted first.
